hangman_engine: RTL and testbench
=================================

HANGMAN_ENGINE -- requirements
Module: hangman_engine

Interface
REQ-001 SHALL have parameter WORD_LEN, default 5, meaning the number of 8-bit ASCII letters in the secret word (legal range 1..16).
REQ-002 SHALL have parameter MAX_MISS, default 6, meaning the number of wrong guesses that ends the game as a loss (legal range 1..15).
REQ-003 SHALL have port clk  input  1  system clock, rising edge.
REQ-004 SHALL have port nRst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port set_valid  input  1  load request for set_word.
REQ-006 SHALL have port set_word  input  8*WORD_LEN  secret word, with letter 0 in the MSB byte.
REQ-007 SHALL have port guess_valid  input  1  guess offered.
REQ-008 SHALL have port guess  input  8  ASCII guess.
REQ-009 SHALL have port guess_ready  output  1  high only in state READY.
REQ-010 SHALL have port revealed  output  WORD_LEN  bit i set once letter i has been guessed (bit WORD_LEN-1 corresponds to letter 0).
REQ-011 SHALL have port result_valid, hit, miss, dup  output  1 each  one-cycle result pulses.
REQ-012 SHALL have port num_miss  output  4  count of misses.
REQ-013 SHALL have port win, lose  output  1 each  level outputs, held while in DONE.
REQ-014 SHALL have port game_rdy  output  1  high in IDLE and DONE (word may be loaded).

Function
REQ-015 SHALL implement FSM states IDLE, READY, SCAN, JUDGE, DONE.
REQ-016 SHALL, in IDLE or DONE when set_valid=1, latch set_word, clear revealed, num_miss, win and lose, and go to READY the next cycle.
REQ-017 SHALL accept a guess when guess_valid and guess_ready are both high, latch guess, clear the hit accumulator, and go to SCAN.
REQ-018 SHALL, in SCAN, compare exactly one letter per cycle at index 0..WORD_LEN-1, set revealed[i] and the hit accumulator on a match, and go to JUDGE after index WORD_LEN-1.
REQ-019 SHALL, in JUDGE, pulse result_valid together with hit (accumulator=1) or miss (accumulator=0), and increment num_miss on a miss.
REQ-020 SHALL produce result_valid exactly WORD_LEN+1 cycles after the accepting edge (non-duplicate guess).
REQ-021 SHALL, from JUDGE, go to DONE with win=1 if revealed is all ones, to DONE with lose=1 if num_miss (post-increment) equals MAX_MISS, and otherwise to READY.
REQ-022 SHALL treat a guess matching an already-revealed letter as a hit, with no change to revealed.
REQ-023 SHALL reveal all positions of a letter that occurs several times in the word from a single guess, and report one hit.
REQ-024 SHALL ignore guess_valid outside READY, and ignore set_valid in READY, SCAN and JUDGE.
REQ-025 SHALL never assert win and lose simultaneously, and SHALL never increment num_miss beyond MAX_MISS.
REQ-026 SHALL hold all inputs latched during SCAN, so that changes on guess or set_word mid-scan have no effect.

Reset
REQ-027 SHALL, while nRst=0, force state IDLE and all outputs to 0 except game_rdy=1; stored word, stored guess and guessed-letter mask SHALL be cleared.
REQ-028 SHALL abandon any in-progress scan on reset, with no result pulse emitted.

Configuration
REQ-029 SHALL, when HANGMAN_DUP_GUESS_EN is defined, keep a 26-bit guessed mask for ASCII 0x41..0x5A, cleared on word load.
REQ-030 SHALL, with HANGMAN_DUP_GUESS_EN defined, handle a repeat guess by skipping SCAN, pulsing result_valid and dup in JUDGE one cycle after acceptance, and leaving num_miss and revealed unchanged.
REQ-031 SHALL, with HANGMAN_DUP_GUESS_EN defined, never flag guesses outside 0x41..0x5A as dup.
REQ-032 SHALL, without HANGMAN_DUP_GUESS_EN, tie dup to 0 and score every guess normally, so that a repeated wrong guess counts as a miss again.

Verification
REQ-033 SHALL cover: load "HELLO", guess 'L' -> after 6 cycles hit=1, revealed=5'b00110, num_miss=0.
REQ-034 SHALL cover: load "HELLO", guess H, E, L, O -> after the 4th result, win=1, state DONE, guess_ready=0.
REQ-035 SHALL cover: load "HELLO", guess six distinct wrong letters -> lose=1 and num_miss=6 at the 6th result, with no further guesses accepted.
REQ-036 SHALL cover: guess 'Z' twice -> with the macro, 2nd result has dup=1 and num_miss=1, 1 cycle after acceptance; without it, num_miss=2.
REQ-037 SHALL cover: nRst asserted during the 3rd SCAN cycle -> immediate IDLE, game_rdy=1, revealed=0, and no result_valid pulse.
REQ-038 SHALL cover: set_valid pulsed during SCAN -> ignored; set_valid in DONE with "WORLD" -> READY, win=0, revealed=0.

Source files
------------

// File: rtl/hangman_engine_if.sv
// Handshake and status bundle between the hangman engine and its controller.
// master drives word loads and guesses; slave is the engine.
interface hangman_engine_if #(
    parameter int WORD_LEN = 5
);
    logic                  set_valid;
    logic [8*WORD_LEN-1:0] set_word;
    logic                  guess_valid;
    logic [7:0]            guess;
    logic                  guess_ready;
    logic [WORD_LEN-1:0]   revealed;
    logic                  result_valid;
    logic                  hit;
    logic                  miss;
    logic                  dup;
    logic [3:0]            num_miss;
    logic                  win;
    logic                  lose;
    logic                  game_rdy;

    modport master (
        output set_valid, set_word, guess_valid, guess,
        input  guess_ready, revealed, result_valid, hit, miss, dup,
               num_miss, win, lose, game_rdy
    );

    modport slave (
        input  set_valid, set_word, guess_valid, guess,
        output guess_ready, revealed, result_valid, hit, miss, dup,
               num_miss, win, lose, game_rdy
    );
endinterface

// File: rtl/hangman_engine.sv
// Hangman game engine: scans the stored word one letter per cycle and scores each guess.
// Define HANGMAN_DUP_GUESS_EN to report repeated A..Z guesses as dup without rescoring them.
module hangman_engine #(
    parameter int WORD_LEN = 5,
    parameter int MAX_MISS = 6
) (
    input logic            clk,
    input logic            nRst,
    hangman_engine_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READY, SCAN, JUDGE, DONE} state_t;

    localparam logic [3:0] LAST_IDX   = 4'(WORD_LEN - 1);
    localparam logic [3:0] MISS_LIMIT = 4'(MAX_MISS);

    state_t                state_q, state_d;
    logic [8*WORD_LEN-1:0] word_q, word_d;
    logic [7:0]            guess_q, guess_d;
    logic [3:0]            idx_q, idx_d;
    logic                  acc_q, acc_d;
    logic                  dup_pend_q, dup_pend_d;
    logic [WORD_LEN-1:0]   revealed_q, revealed_d;
    logic [3:0]            num_miss_q, num_miss_d;
    logic                  result_valid_q, result_valid_d;
    logic                  hit_q, hit_d;
    logic                  miss_q, miss_d;
    logic                  dup_q, dup_d;
    logic                  win_q, win_d;
    logic                  lose_q, lose_d;
    logic                  game_rdy_q, game_rdy_d;
    logic                  guess_ready_q, guess_ready_d;

    logic                  load_en;
    logic                  accept;
    logic                  is_dup;
    logic [WORD_LEN-1:0]   match_vec;

    assign load_en = ((state_q == IDLE) || (state_q == DONE)) && bus.set_valid;
    assign accept  = (state_q == READY) && bus.guess_valid;

    // Only the letter under the scan index can match; bit order follows revealed.
    generate
        for (genvar gi = 0; gi < WORD_LEN; gi++) begin : g_match
            assign match_vec[WORD_LEN-1-gi] = (idx_q == 4'(gi)) &&
                (word_q[8*(WORD_LEN-1-gi) +: 8] == guess_q);
        end
    endgenerate

`ifdef HANGMAN_DUP_GUESS_EN
    logic [25:0] guessed_q, guessed_d;
    logic [25:0] guess_oh;

    // Non-letters decode to all zeros, so they can never be flagged as repeats.
    generate
        for (genvar gi = 0; gi < 26; gi++) begin : g_letter_oh
            assign guess_oh[gi] = (bus.guess == 8'(65 + gi));
        end
    endgenerate

    assign is_dup = |(guess_oh & guessed_q);

    always_comb begin
        guessed_d = guessed_q;
        if (load_en) begin
            guessed_d = '0;
        end else if (accept) begin
            guessed_d = guessed_q | guess_oh;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            guessed_q <= '0;
        end else begin
            guessed_q <= guessed_d;
        end
    end
`else
    assign is_dup = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        word_d         = word_q;
        guess_d        = guess_q;
        idx_d          = idx_q;
        acc_d          = acc_q;
        dup_pend_d     = dup_pend_q;
        revealed_d     = revealed_q;
        num_miss_d     = num_miss_q;
        win_d          = win_q;
        lose_d         = lose_q;
        result_valid_d = 1'b0;
        hit_d          = 1'b0;
        miss_d         = 1'b0;
        dup_d          = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (load_en) begin
                    word_d     = bus.set_word;
                    revealed_d = '0;
                    num_miss_d = '0;
                    win_d      = 1'b0;
                    lose_d     = 1'b0;
                    state_d    = READY;
                end
            end
            READY: begin
                if (accept) begin
                    guess_d    = bus.guess;
                    acc_d      = 1'b0;
                    idx_d      = '0;
                    dup_pend_d = is_dup;
                    state_d    = is_dup ? JUDGE : SCAN;
                end
            end
            SCAN: begin
                revealed_d = revealed_q | match_vec;
                if (|match_vec) begin
                    acc_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = JUDGE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            JUDGE: begin
                result_valid_d = 1'b1;
                if (dup_pend_q) begin
                    dup_d   = 1'b1;
                    state_d = READY;
                end else if (acc_q) begin
                    hit_d = 1'b1;
                    if (&revealed_q) begin
                        win_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = READY;
                    end
                end else begin
                    miss_d = 1'b1;
                    if (num_miss_q < MISS_LIMIT) begin
                        num_miss_d = num_miss_q + 4'd1;
                    end
                    if (num_miss_d == MISS_LIMIT) begin
                        lose_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = READY;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        guess_ready_d = (state_d == READY);
        game_rdy_d    = (state_d == IDLE) || (state_d == DONE);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q        <= IDLE;
            word_q         <= '0;
            guess_q        <= '0;
            idx_q          <= '0;
            acc_q          <= 1'b0;
            dup_pend_q     <= 1'b0;
            revealed_q     <= '0;
            num_miss_q     <= '0;
            result_valid_q <= 1'b0;
            hit_q          <= 1'b0;
            miss_q         <= 1'b0;
            dup_q          <= 1'b0;
            win_q          <= 1'b0;
            lose_q         <= 1'b0;
            game_rdy_q     <= 1'b1;
            guess_ready_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            word_q         <= word_d;
            guess_q        <= guess_d;
            idx_q          <= idx_d;
            acc_q          <= acc_d;
            dup_pend_q     <= dup_pend_d;
            revealed_q     <= revealed_d;
            num_miss_q     <= num_miss_d;
            result_valid_q <= result_valid_d;
            hit_q          <= hit_d;
            miss_q         <= miss_d;
            dup_q          <= dup_d;
            win_q          <= win_d;
            lose_q         <= lose_d;
            game_rdy_q     <= game_rdy_d;
            guess_ready_q  <= guess_ready_d;
        end
    end

    assign bus.guess_ready  = guess_ready_q;
    assign bus.revealed     = revealed_q;
    assign bus.result_valid = result_valid_q;
    assign bus.hit          = hit_q;
    assign bus.miss         = miss_q;
    assign bus.dup          = dup_q;
    assign bus.num_miss     = num_miss_q;
    assign bus.win          = win_q;
    assign bus.lose         = lose_q;
    assign bus.game_rdy     = game_rdy_q;
endmodule

// File: tb/tb_hangman_engine.sv
// Bench for hangman_engine: directed table, multi-cycle corner sequences and random games
// scored by a set-of-guessed-letters model.
module tb_hangman_engine;
    localparam int WL = 5;
    localparam int MM = 6;
    localparam int WB = 8 * WL;
`ifdef HANGMAN_DUP_GUESS_EN
    localparam bit DUP_EN = 1'b1;
`else
    localparam bit DUP_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0]    g;
        int            lat;
        bit            h;
        bit            m;
        bit            d;
        logic [WL-1:0] rev;
        int            nm;
        bit            w;
        bit            l;
    } vec_t;

    logic clk  = 1'b0;
    logic nRst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    hangman_engine_if #(.WORD_LEN(WL)) bus ();

    hangman_engine #(.WORD_LEN(WL), .MAX_MISS(MM)) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [WB-1:0] pack_word(input string s);
        logic [WB-1:0] r;
        r = '0;
        for (int i = 0; i < WL; i++) r[8*(WL-1-i) +: 8] = s[i];
        return r;
    endfunction

    // All tasks start and end at posedge+1.
    task automatic load_word(input string s);
        bus.set_valid = 1'b1;
        bus.set_word  = pack_word(s);
        @(posedge clk); #1;
        bus.set_valid = 1'b0;
        bus.set_word  = WB'({$urandom(), $urandom()});
    endtask

    task automatic pulse_reset();
        nRst = 1'b0;
        @(posedge clk); #1;
        nRst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic guess_once(input logic [7:0] ch, input bit poke, output int lat);
        int w;
        lat = -1;
        w = 0;
        while (!bus.guess_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!bus.guess_ready) return;
        bus.guess_valid = 1'b1;
        bus.guess       = ch;
        @(posedge clk); #1;
        bus.guess_valid = 1'b0;
        bus.guess       = 8'($urandom());
        if (poke) begin
            bus.set_valid = 1'b1;
            bus.set_word  = pack_word("HELLO");
        end
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            bus.set_valid = 1'b0;
            if (bus.result_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic guess_and_check(input string tag, input logic [7:0] ch, input bit poke,
                                   input int e_lat, input bit e_hit, input bit e_miss,
                                   input bit e_dup, input logic [WL-1:0] e_rev, input int e_nm,
                                   input bit e_win, input bit e_lose);
        int lat;
        guess_once(ch, poke, lat);
        $display("guess %s '%c' lat=%0d hit=%0b miss=%0b dup=%0b rev=%b nm=%0d win=%0b lose=%0b",
                 tag, ch, lat, bus.hit, bus.miss, bus.dup, bus.revealed, bus.num_miss,
                 bus.win, bus.lose);
        chk({tag, ".lat"}, lat, e_lat);
        if (lat > 0) begin
            chk({tag, ".hit"}, bus.hit, e_hit);
            chk({tag, ".miss"}, bus.miss, e_miss);
            chk({tag, ".dup"}, bus.dup, e_dup);
            chk({tag, ".revealed"}, bus.revealed, e_rev);
            chk({tag, ".num_miss"}, bus.num_miss, e_nm);
            chk({tag, ".win"}, bus.win, e_win);
            chk({tag, ".lose"}, bus.lose, e_lose);
            chk({tag, ".guess_ready"}, bus.guess_ready, !(e_win || e_lose));
            chk({tag, ".game_rdy"}, bus.game_rdy, e_win || e_lose);
        end
    endtask

    initial begin
        vec_t       tbl[6];
        logic       rv;
        string      lose_letters;

        tbl[0] = '{8'h4C, WL+1, 1'b1, 1'b0, 1'b0, 5'b00110, 0, 1'b0, 1'b0};
        tbl[1] = '{8'h58, WL+1, 1'b0, 1'b1, 1'b0, 5'b00110, 1, 1'b0, 1'b0};
        tbl[2] = '{8'h48, WL+1, 1'b1, 1'b0, 1'b0, 5'b10110, 1, 1'b0, 1'b0};
        tbl[3] = '{8'h45, WL+1, 1'b1, 1'b0, 1'b0, 5'b11110, 1, 1'b0, 1'b0};
        if (DUP_EN) tbl[4] = '{8'h4C, 1, 1'b0, 1'b0, 1'b1, 5'b11110, 1, 1'b0, 1'b0};
        else        tbl[4] = '{8'h4C, WL+1, 1'b1, 1'b0, 1'b0, 5'b11110, 1, 1'b0, 1'b0};
        tbl[5] = '{8'h4F, WL+1, 1'b1, 1'b0, 1'b0, 5'b11111, 1, 1'b1, 1'b0};

        bus.set_valid   = 1'b0;
        bus.set_word    = '0;
        bus.guess_valid = 1'b0;
        bus.guess       = '0;

        nRst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.game_rdy", bus.game_rdy, 1);
        chk("rst.guess_ready", bus.guess_ready, 0);
        chk("rst.revealed", bus.revealed, 0);
        chk("rst.num_miss", bus.num_miss, 0);
        chk("rst.win_lose", {bus.win, bus.lose}, 0);
        chk("rst.pulses", {bus.result_valid, bus.hit, bus.miss, bus.dup}, 0);
        nRst = 1'b1;
        @(posedge clk); #1;

        // Guesses offered in IDLE are ignored.
        bus.guess_valid = 1'b1;
        bus.guess       = "H";
        rv = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            rv |= bus.result_valid;
        end
        bus.guess_valid = 1'b0;
        chk("idle_guess.result_valid", rv, 0);
        chk("idle_guess.game_rdy", bus.game_rdy, 1);

        load_word("HELLO");
        chk("load.guess_ready", bus.guess_ready, 1);
        chk("load.game_rdy", bus.game_rdy, 0);

        for (int i = 0; i < 6; i++) begin
            guess_and_check($sformatf("tbl%0d", i), tbl[i].g, 1'b0, tbl[i].lat, tbl[i].h,
                            tbl[i].m, tbl[i].d, tbl[i].rev, tbl[i].nm, tbl[i].w, tbl[i].l);
        end

        // New word accepted from DONE.
        load_word("WORLD");
        chk("reload.guess_ready", bus.guess_ready, 1);
        chk("reload.win", bus.win, 0);
        chk("reload.revealed", bus.revealed, 0);
        chk("reload.num_miss", bus.num_miss, 0);

        // set_valid during SCAN must not replace WORLD.
        guess_and_check("scan_set", "W", 1'b1, WL+1, 1, 0, 0, 5'b10000, 0, 0, 0);
        guess_and_check("after_set", "H", 1'b0, WL+1, 0, 1, 0, 5'b10000, 1, 0, 0);

        // Reset during the third SCAN cycle.
        bus.guess_valid = 1'b1;
        bus.guess       = "O";
        @(posedge clk); #1;
        bus.guess_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nRst = 1'b0;
        #1;
        chk("scan_rst.game_rdy", bus.game_rdy, 1);
        chk("scan_rst.revealed", bus.revealed, 0);
        chk("scan_rst.guess_ready", bus.guess_ready, 0);
        chk("scan_rst.num_miss", bus.num_miss, 0);
        rv = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            rv |= bus.result_valid;
        end
        nRst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            rv |= bus.result_valid;
        end
        chk("scan_rst.no_result", rv, 0);

        // Six distinct misses lose the game.
        load_word("HELLO");
        lose_letters = "ABCDFG";
        for (int i = 0; i < 6; i++) begin
            guess_and_check($sformatf("lose%0d", i), lose_letters[i], 1'b0, WL+1, 0, 1, 0,
                            5'b00000, i + 1, 0, i == 5);
        end
        bus.guess_valid = 1'b1;
        bus.guess       = "H";
        rv = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            rv |= bus.result_valid;
        end
        bus.guess_valid = 1'b0;
        chk("after_lose.result_valid", rv, 0);
        chk("after_lose.num_miss", bus.num_miss, MM);
        chk("after_lose.lose", bus.lose, 1);
        chk("after_lose.revealed", bus.revealed, 0);

        // Repeated wrong letter, then repeated non-letter.
        load_word("HELLO");
        guess_and_check("z1", "Z", 1'b0, WL+1, 0, 1, 0, 5'b00000, 1, 0, 0);
        guess_and_check("z2", "Z", 1'b0, DUP_EN ? 1 : WL+1, 0, !DUP_EN, DUP_EN, 5'b00000,
                        DUP_EN ? 1 : 2, 0, 0);
        guess_and_check("dig1", "5", 1'b0, WL+1, 0, 1, 0, 5'b00000, DUP_EN ? 2 : 3, 0, 0);
        guess_and_check("dig2", "5", 1'b0, WL+1, 0, 1, 0, 5'b00000, DUP_EN ? 3 : 4, 0, 0);

        // Random games scored by letter-set model.
        for (int gm = 0; gm < 8; gm++) begin
            logic [7:0] w[WL];
            bit         seen[256];
            int         nm;
            bit         fin;
            string      s;
            pulse_reset();
            s = "AAAAA";
            for (int i = 0; i < WL; i++) begin
                w[i] = 8'($urandom_range(65, 72));
                s[i] = w[i];
            end
            load_word(s);
            for (int i = 0; i < 256; i++) seen[i] = 1'b0;
            nm  = 0;
            fin = 1'b0;
            for (int k = 0; k < 40 && !fin; k++) begin
                logic [7:0]    ch;
                bit            isdup;
                bit            inword;
                logic [WL-1:0] rev;
                bit            ew;
                bit            el;
                if ($urandom_range(0, 9) == 0) ch = 8'($urandom_range(48, 57));
                else                           ch = 8'($urandom_range(65, 74));
                isdup  = DUP_EN && ch >= 8'd65 && ch <= 8'd90 && seen[ch];
                inword = 1'b0;
                for (int i = 0; i < WL; i++) if (w[i] == ch) inword = 1'b1;
                seen[ch] = 1'b1;
                if (!isdup && !inword) nm++;
                for (int i = 0; i < WL; i++) rev[WL-1-i] = seen[w[i]];
                ew = !isdup && inword && (&rev);
                el = !isdup && !inword && (nm == MM);
                guess_and_check($sformatf("rnd%0d_%0d", gm, k), ch, 1'b0, isdup ? 1 : WL+1,
                                !isdup && inword, !isdup && !inword, isdup, rev, nm, ew, el);
                fin = ew || el;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
